fir_filter_param: RTL

Parametrised, fully pipelined direct-form FIR filter with signed arithmetic and runtime-reloadable coefficients. It is the successor to the fixed 4-tap block. It generalises tap count and data/coefficient widths, and it replaces the static coefficient array with a double-buffered write port: new coefficients take effect atomically on commit, without glitching an in-flight stream. It sits in the sample datapath between the input source and downstream decimation/readout, and is driven by a single `valid_in`/`valid_out` qualifier (no backpressure).

---
 rtl/fir_filter_param.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param
//   Pipelined direct-form FIR filter with signed full-precision arithmetic and
//   a double-buffered coefficient store (shadow bank written at any time,
//   copied atomically into the active bank on commit).
//
//   Ports
//     clk           system clock, rising edge
//     rst           synchronous active-high reset
//     valid_in      signal carries a new sample this cycle
//     signal        signed input sample (DATA_W)
//     flush         clear delay line and pipeline, coefficients kept
//     coef_wr_en    write coef_wr_data into shadow[coef_wr_addr]
//     coef_wr_addr  shadow index, 0 = tap applied to the newest sample
//     coef_wr_data  signed coefficient (COEF_W)
//     coef_commit   copy the whole shadow bank into the active bank
//     coef_swapped  one-cycle pulse the cycle after a commit takes effect
//     valid_out     signal_out holds a new result this cycle
//     signal_out    signed filter output (OUT_W)
//
//   Latency is two edges: products are registered on the accepting edge,
//   their sum is registered into signal_out on the following edge.

module fir_filter_param #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic signed [DATA_W-1:0]   signal,
  input  logic                       flush,
  input  logic                       coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coef_wr_addr,
  input  logic signed [COEF_W-1:0]   coef_wr_data,
  input  logic                       coef_commit,
  output logic                       coef_swapped,
  output logic                       valid_out,
  output logic signed [OUT_W-1:0]    signal_out
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int GUARD  = OUT_W - PROD_W;
  localparam logic [AW:0] TAPS_L = (AW + 1)'(TAPS);

  // ---------------------------------------------------------------------------
  // Coefficient banks
  // ---------------------------------------------------------------------------
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic                     swapped_q;
  logic                     wr_hit;

  // Addresses beyond the last tap are dropped; the extra bit keeps the compare
  // meaningful when TAPS is a power of two.
  assign wr_hit = coef_wr_en && ({1'b0, coef_wr_addr} < TAPS_L);

  // Commit reads shadow_q before this edge's write lands, so a same-edge
  // write only reaches the shadow bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      swapped_q <= 1'b0;
    end else begin
      if (wr_hit) begin
        shadow_q[coef_wr_addr] <= coef_wr_data;
      end
      if (coef_commit) begin
        for (int k = 0; k < TAPS; k++) begin
          active_q[k] <= shadow_q[k];
        end
      end
      swapped_q <= coef_commit;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: delay line and registered products
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] dly_q  [TAPS-1];
  logic signed [DATA_W-1:0] tap_w  [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic                     vld1_q;

  always_comb begin
    tap_w[0] = signal;
    for (int k = 1; k < TAPS; k++) begin
      tap_w[k] = dly_q[k-1];
    end
  end

  // Both operands are sign-extended to the product width so the multiply is
  // exact regardless of how the tool sizes the expression.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = $signed({{COEF_W{tap_w[k][DATA_W-1]}}, tap_w[k]})
                * $signed({{DATA_W{active_q[k][COEF_W-1]}}, active_q[k]});
    end
  end

  // The products use active_q as it was before this edge, which is what makes
  // a sample accepted on a commit edge still see the old coefficients.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        dly_q[k] <= '0;
      end
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= '0;
      end
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= valid_in;
      if (valid_in) begin
        dly_q[0] <= signal;
        for (int k = 1; k < TAPS - 1; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
        for (int k = 0; k < TAPS; k++) begin
          prod_q[k] <= prod_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: adder tree into the output register
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] sum_d;
  logic signed [OUT_W-1:0] signal_out_q;
  logic                    valid_out_q;

  // GUARD is at least $clog2(TAPS) bits, so the running sum cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + {{GUARD{prod_q[k][PROD_W-1]}}, prod_q[k]};
    end
  end

  // Flush drops the result in flight but leaves the last output on display.
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_out_q <= '0;
      valid_out_q  <= 1'b0;
    end else if (flush) begin
      valid_out_q  <= 1'b0;
    end else begin
      valid_out_q <= vld1_q;
      if (vld1_q) begin
        signal_out_q <= sum_d;
      end
    end
  end

  assign coef_swapped = swapped_q;
  assign valid_out    = valid_out_q;
  assign signal_out   = signal_out_q;

endmodule
